// File: rtl/alu_share_pkg.sv
// Shared types and constants for the alu_share_ctrl sequencer: op encodings,
// sequencer states and condition-code layout.
package alu_share_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NEG,
        ST_EXEC,
        ST_RESP
    } state_e;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RESET = 3'b100;

    function automatic logic [2:0] cc_flags(input logic [63:0] res, input logic of);
        logic [2:0] cc;
        cc        = 3'b000;
        cc[CC_ZF] = (res == 64'd0);
        cc[CC_SF] = res[63];
        cc[CC_OF] = of;
        return cc;
    endfunction

endpackage

// File: rtl/add64.sv
// 64-bit ripple-carry adder with carry-in tied to zero; reports signed overflow.
module add64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum,
    output logic        ovf
);

    always_comb begin : ripple
        logic carry;
        logic carry_msb;
        sum       = '0;
        carry     = 1'b0;
        carry_msb = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) carry_msb = carry;
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        // Signed overflow: carry into the sign bit differs from carry out of it.
        ovf = carry ^ carry_msb;
    end

endmodule

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant among valid requesters, priority
// passes to the other requester after every grant.
module rr_arb2 #(
    parameter int RR_INIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic prio_q, prio_d;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch is inferred.
        grant  = 2'b00;
        prio_d = prio_q;
        if (en) begin
            if (valid == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
            else                grant = valid;
            if (grant != 2'b00) prio_d = ~grant[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment only.
        if (!rst_n) prio_q <= 1'(RR_INIT);
        else        prio_q <= prio_d;
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one add64 and the logic ops between two requesters with round-robin
// grant. Optional condition-code register enabled by `define ALU_SHARE_CC_EN.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int W       = 64,
    parameter int RR_INIT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [3:0]     req_op,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    input  logic [1:0]     req_setcc,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [W-1:0]   resp_data,
    output logic           resp_of,
    output logic [2:0]     cc_out
);

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic           b_sign_q, b_sign_d;
    logic           setcc_q, setcc_d;
    logic           id_q, id_d;
    logic           of_q, of_d;

    logic [1:0]     grant;
    logic           gsel;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           add_ovf;

    rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_IDLE && rst_n),
        .valid (req_valid),
        .grant (grant)
    );

    add64 u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign gsel = grant[1];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        b_sign_d = b_sign_q;
        setcc_d  = setcc_q;
        id_d     = id_q;
        res_d    = res_q;
        of_d     = of_q;
        add_a    = a_q;
        add_b    = b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    id_d     = gsel;
                    op_d     = op_e'(req_op[2*int'(gsel) +: 2]);
                    a_d      = req_a[W*int'(gsel) +: W];
                    b_d      = req_b[W*int'(gsel) +: W];
                    b_sign_d = b_d[W-1];
                    setcc_d  = req_setcc[gsel];
                    state_d  = (op_d == OP_SUB) ? ST_NEG : ST_EXEC;
                end
            end
            ST_NEG: begin
                // Two's-complement negate of B through the shared adder.
                add_a   = ~b_q;
                add_b   = W'(1);
                b_d     = add_sum;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                unique case (op_q)
                    OP_ADD: begin
                        res_d = add_sum;
                        of_d  = add_ovf;
                    end
                    OP_SUB: begin
                        // Uses the original sign of B; negate overflow of B=min is not reported.
                        res_d = add_sum;
                        of_d  = (a_q[W-1] != b_sign_q) && (add_sum[W-1] != a_q[W-1]);
                    end
                    OP_AND: begin
                        res_d = a_q & b_q;
                        of_d  = 1'b0;
                    end
                    OP_XOR: begin
                        res_d = a_q ^ b_q;
                        of_d  = 1'b0;
                    end
                endcase
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset too, so resp_data/resp_id read 0 after reset.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            b_sign_q <= 1'b0;
            setcc_q  <= 1'b0;
            id_q     <= 1'b0;
            res_q    <= '0;
            of_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            b_sign_q <= b_sign_d;
            setcc_q  <= setcc_d;
            id_q     <= id_d;
            res_q    <= res_d;
            of_q     <= of_d;
        end
    end

    assign req_ready  = grant;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_id    = id_q;
    assign resp_data  = res_q;
    assign resp_of    = of_q;

`ifdef ALU_SHARE_CC_EN
    logic [2:0] cc_q, cc_d;

    always_comb begin
        cc_d = cc_q;
        if (state_q == ST_RESP && resp_ready && setcc_q) cc_d = cc_flags(res_q, of_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cc_q <= CC_RESET;
        else        cc_q <= cc_d;
    end

    assign cc_out = cc_q;
`else
    logic unused_setcc;
    assign unused_setcc = setcc_q;
    assign cc_out       = 3'b000;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: transaction-level model plus directed
// literal checks; build with +define+ALU_SHARE_CC_EN to cover the CC register.
module tb_alu_share_ctrl;

`ifdef ALU_SHARE_CC_EN
    localparam logic [2:0] CC_RST_EXP = 3'b100;
    localparam bit         CC_ON      = 1'b1;
`else
    localparam logic [2:0] CC_RST_EXP = 3'b000;
    localparam bit         CC_ON      = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [3:0]   req_op;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [1:0]   req_setcc;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_id;
    logic [63:0]  resp_data;
    logic         resp_of;
    logic [2:0]   cc_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int accept_cyc = 0;
    bit log_en   = 0;
    logic grant_log[$];

    alu_share_ctrl #(.W(64), .RR_INIT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_setcc  (req_setcc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_of    (resp_of),
        .cc_out     (cc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_pending;
    int          m_cnt, m_lat;
    bit          m_prio;
    logic        m_id, m_of, m_sc;
    logic [63:0] m_res;
    logic [2:0]  m_cc;

    function automatic logic [1:0] pick(input logic [1:0] v, input bit p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic golden(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] r, output logic of);
        logic signed [64:0] wide;
        of = 1'b0;
        case (op)
            2'b00: begin
                wide = $signed({a[63], a}) + $signed({b[63], b});
                r    = wide[63:0];
                of   = (wide > 65'sd9223372036854775807) || (wide < -65'sd9223372036854775808);
            end
            2'b01: begin
                wide = $signed({a[63], a}) - $signed({b[63], b});
                r    = wide[63:0];
                of   = (wide > 65'sd9223372036854775807) || (wide < -65'sd9223372036854775808);
            end
            2'b10:   r = a & b;
            default: r = a ^ b;
        endcase
    endtask

    always @(negedge clk) begin : model
        logic [1:0] exp_ready;
        bit         exp_rv;
        if (!rst_n) begin
            m_pending = 0;
            m_prio    = 0;
            m_cc      = CC_RST_EXP;
            check("rst_req_ready", {62'd0, req_ready}, 64'd0);
            check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
            check("rst_resp_id", {63'd0, resp_id}, 64'd0);
            check("rst_resp_data", resp_data, 64'd0);
            check("rst_resp_of", {63'd0, resp_of}, 64'd0);
            check("rst_cc_out", {61'd0, cc_out}, {61'd0, CC_RST_EXP});
        end else begin
            if (m_pending) m_cnt++;
            exp_rv    = m_pending && (m_cnt >= m_lat);
            exp_ready = m_pending ? 2'b00 : pick(req_valid, m_prio);
            check("m_req_ready", {62'd0, req_ready}, {62'd0, exp_ready});
            check("m_resp_valid", {63'd0, resp_valid}, {63'd0, exp_rv});
            if (exp_rv) begin
                check("m_resp_id", {63'd0, resp_id}, {63'd0, m_id});
                check("m_resp_data", resp_data, m_res);
                check("m_resp_of", {63'd0, resp_of}, {63'd0, m_of});
            end
            check("m_cc_out", {61'd0, cc_out}, {61'd0, m_cc});
            if (log_en && req_ready != 2'b00) grant_log.push_back(req_ready[1]);
            if (exp_rv && resp_ready) begin
                m_pending = 0;
                if (CC_ON && m_sc) m_cc = {m_res == 64'd0, m_res[63], m_of};
            end else if (exp_ready != 2'b00) begin
                m_id = exp_ready[1];
                golden(req_op[2*int'(m_id) +: 2], req_a[64*int'(m_id) +: 64],
                       req_b[64*int'(m_id) +: 64], m_res, m_of);
                m_sc      = req_setcc[m_id];
                m_lat     = (req_op[2*int'(m_id) +: 2] == 2'b01) ? 3 : 2;
                m_cnt     = 0;
                m_pending = 1;
                m_prio    = ~m_id;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input int id, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic sc);
        bit got = 0;
        @(posedge clk); #1;
        req_valid[id]       = 1'b1;
        req_op[2*id +: 2]   = op;
        req_a[64*id +: 64]  = a;
        req_b[64*id +: 64]  = b;
        req_setcc[id]       = sc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1;
                accept_cyc = cyc;
                break;
            end
        end
        if (!got) check("issue_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic collect(input string nm, input logic id, input logic [63:0] d,
                           input logic of, input int lat);
        bit got = 0;
        int l = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1;
                l = cyc - accept_cyc;
                break;
            end
        end
        if (!got) check({nm, "_timeout"}, 64'd0, 64'd1);
        else begin
            check({nm, "_latency"}, 64'(l), 64'(lat));
            check({nm, "_id"}, {63'd0, resp_id}, {63'd0, id});
            check({nm, "_data"}, resp_data, d);
            check({nm, "_of"}, {63'd0, resp_of}, {63'd0, of});
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : stim
        logic [63:0] held;
        bit got;
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        req_op     = 4'd0;
        req_a      = '0;
        req_b      = '0;
        req_setcc  = 2'b00;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: ADD 5+7 from requester 0
        issue(0, 2'b00, 64'd5, 64'd7, 1'b0);
        collect("t1_add", 1'b0, 64'd12, 1'b0, 2);

        // 2: SUB 3-10 from requester 1, updating CC
        issue(1, 2'b01, 64'd3, 64'd10, 1'b1);
        collect("t2_sub", 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 3);
        @(negedge clk);
        check("t2_cc", {61'd0, cc_out}, CC_ON ? 64'd2 : 64'd0);

        // 3: signed overflow on ADD and SUB
        issue(0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        collect("t3_add_of", 1'b0, 64'h8000_0000_0000_0000, 1'b1, 2);
        issue(1, 2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
        collect("t3_sub_of", 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 3);
        issue(0, 2'b11, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
        collect("t3_xor", 1'b0, 64'hF0F0_0F0F_F0F0_0F0F, 1'b0, 2);

        // 5: stalled response stays stable, nothing accepted meanwhile
        resp_ready = 1'b0;
        issue(0, 2'b10, 64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_FF00, 1'b0);
        req_valid[1]     = 1'b1;
        req_op[3:2]      = 2'b00;
        req_a[127:64]    = 64'd40;
        req_b[127:64]    = 64'd2;
        got = 0;
        held = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1;
                held = resp_data;
                break;
            end
        end
        if (!got) check("t5_timeout", 64'd0, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_valid_held", {63'd0, resp_valid}, 64'd1);
            check("t5_data_held", resp_data, held);
            check("t5_data", resp_data, 64'h0000_0000_0000_F000);
            check("t5_ready_zero", {62'd0, req_ready}, 64'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready[1]) begin
                got = 1;
                break;
            end
        end
        if (!got) check("t5_regrant_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (4) @(posedge clk);

        // 6: reset during NEG of a SUB aborts it
        issue(1, 2'b01, 64'd100, 64'd1, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_resp", {63'd0, resp_valid}, 64'd0);
            check("t6_cc", {61'd0, cc_out}, {61'd0, CC_RST_EXP});
        end
        issue(0, 2'b00, 64'd20, 64'd22, 1'b0);
        collect("t6_add", 1'b0, 64'd42, 1'b0, 2);

        // 4: both requesters valid continuously, priority 0 after reset
        pulse_reset();
        grant_log.delete();
        req_op        = 4'b1100;
        req_a[63:0]   = 64'd100;
        req_b[63:0]   = 64'd1;
        req_a[127:64] = 64'h00FF;
        req_b[127:64] = 64'h0F0F;
        req_setcc     = 2'b00;
        log_en        = 1;
        req_valid     = 2'b11;
        repeat (16) @(posedge clk);
        #1 req_valid = 2'b00;
        log_en = 0;
        check("t4_grant_count", 64'(grant_log.size() >= 4), 64'd1);
        if (grant_log.size() >= 4) begin
            check("t4_grant0", {63'd0, grant_log[0]}, 64'd0);
            check("t4_grant1", {63'd0, grant_log[1]}, 64'd1);
            check("t4_grant2", {63'd0, grant_log[2]}, 64'd0);
            check("t4_grant3", {63'd0, grant_log[3]}, 64'd1);
        end
        repeat (6) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
